// File: rtl/fdtd_hy_update.sv
// 1-D FDTD magnetic-field update: Hy_n[i] = Hy_old[i] + coef*(Ez_old[i+1]-Ez_old[i]).
// Streams one cell per cycle from the old-field RAMs into the current-Hy RAM.
//
// state | meaning
// IDLE  | waiting for start_i; N and coef latched on start
// CHECK | reject N==0 or N>2**AW-1
// PRIME | read Ez[0] so the first difference has its left neighbour
// RUN   | read Hy[k], Ez[k+1] for k=0..N-1
// DRAIN | 3 cycles letting the last cells leave the pipeline
// DONE  | done_o (and err_o if N was rejected) for one cycle
module fdtd_hy_update #(
  parameter int FDTD_DATA_WIDTH   = 32,
  parameter int BUFFER_ADDR_WIDTH = 6,
  parameter int FRAC_BITS         = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         start_i,
  input  logic [BUFFER_ADDR_WIDTH:0]   cell_num_i,
  input  logic [FDTD_DATA_WIDTH-1:0]   coef_i,
  output logic                         rd_Hy_old_en_o,
  output logic [BUFFER_ADDR_WIDTH-1:0] rd_Hy_old_addr_o,
  input  logic [FDTD_DATA_WIDTH-1:0]   Hy_old_i,
  output logic                         rd_Ez_old_en_o,
  output logic [BUFFER_ADDR_WIDTH-1:0] rd_Ez_old_addr_o,
  input  logic [FDTD_DATA_WIDTH-1:0]   Ez_old_i,
  output logic                         wrt_Hy_n_en_o,
  output logic [BUFFER_ADDR_WIDTH-1:0] wrt_Hy_n_addr_o,
  output logic [FDTD_DATA_WIDTH-1:0]   Hy_n_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o
);
  localparam int DW = FDTD_DATA_WIDTH;
  localparam int AW = BUFFER_ADDR_WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_PRIME = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Ez needs N+1 entries, so the largest legal N is one short of the RAM depth.
  localparam logic [AW:0] N_MAX = {1'b0, {AW{1'b1}}};

  logic [2:0]           state;
  logic [AW:0]          rem_q;
  logic [AW-1:0]        k_q;
  logic [1:0]           drain_q;
  logic signed [DW-1:0] coef_q;
  logic                 err_q;

  logic                 rd_ez_q, rd_hy_q;
  logic [AW-1:0]        rd_addr_q;
  logic signed [DW-1:0] ez_prev;
  logic signed [DW:0]   diff_q;
  logic signed [DW-1:0] hy_q;
  logic                 s1_v;
  logic [AW-1:0]        s1_addr;

  logic signed [DW:0]     diff_d;
  logic signed [2*DW:0]   prod_full;
  logic signed [2*DW:0]   prod_sh;
  logic signed [2*DW+1:0] sum_full;
  logic [DW-1:0]          sum_sat;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      rem_q   <= '0;
      k_q     <= '0;
      drain_q <= '0;
      coef_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            rem_q  <= cell_num_i;
            coef_q <= coef_i;
            err_q  <= 1'b0;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          k_q <= '0;
          if (rem_q == '0 || rem_q > N_MAX) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_PRIME;
          end
        end
        S_PRIME: state <= S_RUN;
        S_RUN: begin
          k_q   <= k_q + AW'(1);
          rem_q <= rem_q - (AW+1)'(1);
          if (rem_q == (AW+1)'(1)) begin
            drain_q <= 2'd2;
            state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          drain_q <= drain_q - 2'd1;
          if (drain_q == 2'd0) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_Ez_old_en_o   = 1'b0;
    rd_Ez_old_addr_o = '0;
    rd_Hy_old_en_o   = 1'b0;
    rd_Hy_old_addr_o = '0;
    if (state == S_PRIME) begin
      rd_Ez_old_en_o = 1'b1;
    end else if (state == S_RUN) begin
      rd_Ez_old_en_o   = 1'b1;
      rd_Ez_old_addr_o = k_q + AW'(1);
      rd_Hy_old_en_o   = 1'b1;
      rd_Hy_old_addr_o = k_q;
    end
  end

  assign busy_o = (state != S_IDLE);
  assign done_o = (state == S_DONE);
  assign err_o  = (state == S_DONE) && err_q;

  always_comb begin
    diff_d    = $signed({Ez_old_i[DW-1], Ez_old_i}) - $signed({ez_prev[DW-1], ez_prev});
    prod_full = $signed({{DW{diff_q[DW]}}, diff_q}) * $signed({{(DW+1){coef_q[DW-1]}}, coef_q});
    prod_sh   = prod_full >>> FRAC_BITS;
    sum_full  = $signed({{(DW+2){hy_q[DW-1]}}, hy_q}) + $signed({prod_sh[2*DW], prod_sh});
    // In range when every bit above the DW-bit sign agrees with it.
    if (sum_full[2*DW+1:DW-1] == {(DW+3){1'b0}} || sum_full[2*DW+1:DW-1] == {(DW+3){1'b1}})
      sum_sat = sum_full[DW-1:0];
    else if (sum_full[2*DW+1])
      sum_sat = {1'b1, {(DW-1){1'b0}}};
    else
      sum_sat = {1'b0, {(DW-1){1'b1}}};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ez_q         <= 1'b0;
      rd_hy_q         <= 1'b0;
      rd_addr_q       <= '0;
      ez_prev         <= '0;
      diff_q          <= '0;
      hy_q            <= '0;
      s1_v            <= 1'b0;
      s1_addr         <= '0;
      wrt_Hy_n_en_o   <= 1'b0;
      wrt_Hy_n_addr_o <= '0;
      Hy_n_o          <= '0;
    end else begin
      rd_ez_q   <= rd_Ez_old_en_o;
      rd_hy_q   <= rd_Hy_old_en_o;
      rd_addr_q <= rd_Hy_old_addr_o;
      if (rd_ez_q) ez_prev <= Ez_old_i;
      s1_v <= rd_hy_q;
      if (rd_hy_q) begin
        diff_q  <= diff_d;
        hy_q    <= Hy_old_i;
        s1_addr <= rd_addr_q;
      end
      wrt_Hy_n_en_o <= s1_v;
      if (s1_v) begin
        Hy_n_o          <= sum_sat;
        wrt_Hy_n_addr_o <= s1_addr;
      end
    end
  end
endmodule

// File: tb/tb_fdtd_hy_update.sv
// Bench for fdtd_hy_update: RAM model, write monitor and a plain-arithmetic reference.
module tb_fdtd_hy_update;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int FB = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start_i = 1'b0;
  logic [AW:0]   cell_num_i = '0;
  logic [DW-1:0] coef_i = '0;
  logic          rd_Hy_old_en_o, rd_Ez_old_en_o, wrt_Hy_n_en_o;
  logic [AW-1:0] rd_Hy_old_addr_o, rd_Ez_old_addr_o, wrt_Hy_n_addr_o;
  logic [DW-1:0] Hy_old_i = '0;
  logic [DW-1:0] Ez_old_i = '0;
  logic [DW-1:0] Hy_n_o;
  logic          busy_o, done_o, err_o;

  fdtd_hy_update #(.FDTD_DATA_WIDTH(DW), .BUFFER_ADDR_WIDTH(AW), .FRAC_BITS(FB)) dut (
    .CLK(CLK), .RST(RST), .start_i(start_i), .cell_num_i(cell_num_i), .coef_i(coef_i),
    .rd_Hy_old_en_o(rd_Hy_old_en_o), .rd_Hy_old_addr_o(rd_Hy_old_addr_o), .Hy_old_i(Hy_old_i),
    .rd_Ez_old_en_o(rd_Ez_old_en_o), .rd_Ez_old_addr_o(rd_Ez_old_addr_o), .Ez_old_i(Ez_old_i),
    .wrt_Hy_n_en_o(wrt_Hy_n_en_o), .wrt_Hy_n_addr_o(wrt_Hy_n_addr_o), .Hy_n_o(Hy_n_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [DW-1:0] hy_mem [64];
  logic [DW-1:0] ez_mem [64];
  always @(posedge CLK) begin
    if (rd_Hy_old_en_o) Hy_old_i <= hy_mem[rd_Hy_old_addr_o];
    if (rd_Ez_old_en_o) Ez_old_i <= ez_mem[rd_Ez_old_addr_o];
  end

  int            wcnt = 0;
  int            rcnt = 0;
  int            wr_addr [1024];
  logic [DW-1:0] wr_data [1024];
  int            wr_cyc  [1024];
  always @(negedge CLK) begin
    if (wrt_Hy_n_en_o && wcnt < 1024) begin
      wr_addr[wcnt] = int'(wrt_Hy_n_addr_o);
      wr_data[wcnt] = Hy_n_o;
      wr_cyc[wcnt]  = cyc;
      wcnt++;
    end
    if (rd_Hy_old_en_o || rd_Ez_old_en_o) rcnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hy + floor(coef*(ez1-ez0) / 2**FB), clamped to the signed DW-bit range.
  function automatic logic [DW-1:0] ref_hy(input logic signed [DW-1:0] hy, ez1, ez0, coef);
    logic signed [127:0] a, b, c, h, s;
    a = ez1; b = ez0; c = coef; h = hy;
    s = h + (((a - b) * c) >>> FB);
    if (s > 128'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    if (s < -128'sh8000_0000) return 32'h8000_0000;
    return s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic signed [DW-1:0] v;
    v = $signed($urandom);
    return v >>> $urandom_range(0, 14);
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      hy_mem[i] = rnd();
      ez_mem[i] = rnd();
    end
  endtask

  task automatic do_run(input int n, input logic [DW-1:0] coef, input bit mid_start,
                        input string tag, output int wb);
    int  m, rb, dcyc, nw;
    bit  found, derr, legal;
    legal = (n >= 1 && n <= 63);
    wb = wcnt;
    rb = rcnt;
    @(posedge CLK); #1;
    start_i = 1'b1; cell_num_i = (AW+1)'(n); coef_i = coef; m = cyc;
    @(posedge CLK); #1;
    start_i = 1'b0; cell_num_i = (AW+1)'($urandom); coef_i = $urandom;
    found = 0; dcyc = 0; derr = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge CLK);
      if (mid_start) start_i = (i == 3);
      if (done_o) begin
        found = 1; dcyc = cyc; derr = err_o;
        break;
      end
    end
    start_i = 1'b0;
    chk({tag, " done_seen"}, 64'(found), 64'd1);
    chk({tag, " done_cycle"}, 64'(dcyc), 64'(m + (legal ? n + 6 : 2)));
    chk({tag, " err"}, 64'(derr), 64'(!legal));
    chk({tag, " busy_at_done"}, 64'(busy_o), 64'd1);
    nw = wcnt - wb;
    chk({tag, " write_count"}, 64'(nw), 64'(legal ? n : 0));
    chk({tag, " read_cycles"}, 64'(rcnt - rb), 64'(legal ? n + 1 : 0));
    for (int k = 0; k < nw && k < n && k < 63; k++) begin
      chk({tag, " wr_addr"}, 64'(wr_addr[wb+k]), 64'(k));
      chk({tag, " wr_data"}, 64'(wr_data[wb+k]), 64'(ref_hy(hy_mem[k], ez_mem[k+1], ez_mem[k], coef)));
      chk({tag, " wr_cycle"}, 64'(wr_cyc[wb+k]), 64'(m + k + 6));
    end
  endtask

  initial begin
    int wb, m;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst busy", 64'(busy_o), 64'd0);
    chk("rst done", 64'(done_o), 64'd0);
    chk("rst err", 64'(err_o), 64'd0);
    chk("rst wrt_en", 64'(wrt_Hy_n_en_o), 64'd0);
    chk("rst rd_en", 64'({rd_Hy_old_en_o, rd_Ez_old_en_o}), 64'd0);
    chk("rst Hy_n", 64'(Hy_n_o), 64'd0);

    // Ez = 0,1,3,6,10 gives unit-step differences 1..4
    for (int i = 0; i < 64; i++) begin hy_mem[i] = '0; ez_mem[i] = '0; end
    ez_mem[1] = 32'h0001_0000; ez_mem[2] = 32'h0003_0000;
    ez_mem[3] = 32'h0006_0000; ez_mem[4] = 32'h000A_0000;
    do_run(4, 32'h0001_0000, 1'b0, "t1", wb);
    for (int k = 0; k < 4; k++) chk("t1 const", 64'(wr_data[wb+k]), 64'((k + 1) << 16));

    ez_mem[0] = 32'h0001_0000; ez_mem[1] = 32'h0003_0000; hy_mem[0] = 32'h0001_0000;
    do_run(1, 32'h0000_8000, 1'b0, "t2", wb);
    chk("t2 const", 64'(wr_data[wb]), 64'h0002_0000);

    hy_mem[0] = 32'h7FFF_0000; hy_mem[1] = 32'h8000_0000;
    ez_mem[0] = 32'h0;         ez_mem[1] = 32'h0002_0000; ez_mem[2] = 32'h0;
    do_run(2, 32'h0001_0000, 1'b0, "t3", wb);
    chk("t3 sat_pos", 64'(wr_data[wb]), 64'h7FFF_FFFF);
    chk("t3 sat_neg", 64'(wr_data[wb+1]), 64'h8000_0000);

    do_run(0, 32'h0001_0000, 1'b0, "t4_n0", wb);
    do_run(64, 32'h0001_0000, 1'b0, "t4_n64", wb);
    do_run(63, 32'h0000_4000, 1'b0, "t4_n63", wb);

    fill_random();
    wb = wcnt;
    @(posedge CLK); #1;
    start_i = 1'b1; cell_num_i = 7'd8; coef_i = 32'h0001_0000; m = cyc;
    @(posedge CLK); #1 start_i = 1'b0;
    repeat (4) @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    chk("t5 run_k2", 64'(rd_Hy_old_addr_o), 64'd2);
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    chk("t5 cycle", 64'(cyc), 64'(m + 6));
    chk("t5 rd_en", 64'({rd_Hy_old_en_o, rd_Ez_old_en_o}), 64'd0);
    chk("t5 wrt_en", 64'(wrt_Hy_n_en_o), 64'd0);
    chk("t5 busy", 64'(busy_o), 64'd0);
    repeat (6) @(negedge CLK);
    chk("t5 no_writes", 64'(wcnt - wb), 64'd0);
    do_run(8, rnd(), 1'b0, "t5_rerun", wb);

    fill_random();
    do_run(6, rnd(), 1'b1, "t6_mid", wb);
    do_run(int'($urandom_range(1, 63)), rnd(), 1'b0, "t6_b2b_a", wb);
    do_run(int'($urandom_range(1, 63)), rnd(), 1'b0, "t6_b2b_b", wb);
    @(negedge CLK);
    @(negedge CLK);
    chk("t6 idle_busy", 64'(busy_o), 64'd0);

    for (int r = 0; r < 4; r++) begin
      fill_random();
      do_run(int'($urandom_range(1, 63)), $signed($urandom) >>> 10, 1'b0, "rand", wb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
